// File: rtl/y86_seq_ctrl.sv
// Multi-cycle sequencer for the Y86-64 SEQ datapath: owns the PC, steps each
// instruction through its phases, handshakes with data memory and tracks status.
module y86_seq_ctrl #(
    parameter logic [63:0] RESET_PC    = 64'h0,
    parameter int          MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        step_mode,
    input  logic [3:0]  icode,
    input  logic [63:0] valC,
    input  logic [63:0] valP,
    input  logic        instr_valid,
    input  logic        imem_error,
    input  logic        Cnd,
    input  logic [63:0] valM,
    input  logic        dmem_done,
    input  logic        dmem_error,
    output logic [63:0] PC,
    output logic        f_en,
    output logic        d_en,
    output logic        e_en,
    output logic        w_en,
    output logic        dmem_req,
    output logic [2:0]  stat,
    output logic        busy,
    output logic [31:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_PCUPD, S_HALT
    } state_t;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t      state, state_nx;
    logic [3:0]  icode_q;
    logic [63:0] valc_q, valp_q, valm_q;
    logic        cnd_q;
    logic [7:0]  wait_cnt;
    logic        mem_timeout;

    // rmmovq, mrmovq, call, ret, pushq, popq touch data memory
    function automatic logic is_mem_op(input logic [3:0] ic);
        return (ic == 4'h4) || (ic == 4'h5) || (ic == 4'h8) ||
               (ic == 4'h9) || (ic == 4'hA) || (ic == 4'hB);
    endfunction

    function automatic logic [63:0] sel_next_pc(input logic [3:0] ic, input logic cnd,
                                                 input logic [63:0] vc, input logic [63:0] vp,
                                                 input logic [63:0] vm);
        case (ic)
            4'h8:    return vc;
            4'h7:    return cnd ? vc : vp;
            4'h9:    return vm;
            default: return vp;
        endcase
    endfunction

    // wait_cnt holds completed MEM cycles, so this is the MEM_TIMEOUT-th cycle
    assign mem_timeout = (wait_cnt == WAIT_LAST);
    assign busy = (state != S_IDLE) && (state != S_HALT);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        f_en     = 1'b0;
        d_en     = 1'b0;
        e_en     = 1'b0;
        w_en     = 1'b0;
        dmem_req = 1'b0;
        case (state)
            S_IDLE:   if (start) state_nx = S_FETCH;
            S_FETCH: begin
                f_en = 1'b1;
                if (imem_error || !instr_valid || icode == 4'h0) state_nx = S_HALT;
                else                                              state_nx = S_DECODE;
            end
            S_DECODE: begin
                d_en     = 1'b1;
                state_nx = S_EXEC;
            end
            S_EXEC: begin
                e_en     = 1'b1;
                state_nx = is_mem_op(icode_q) ? S_MEM : S_WB;
            end
            S_MEM: begin
                dmem_req = 1'b1;
                if (dmem_done)        state_nx = dmem_error ? S_HALT : S_WB;
                else if (mem_timeout) state_nx = S_HALT;
            end
            S_WB: begin
                w_en     = 1'b1;
                state_nx = S_PCUPD;
            end
            S_PCUPD:  state_nx = step_mode ? S_IDLE : S_FETCH;
            default:  state_nx = S_HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            PC          <= RESET_PC;
            stat        <= STAT_AOK;
            instr_count <= 32'd0;
            icode_q     <= 4'h0;
            valc_q      <= 64'h0;
            valp_q      <= 64'h0;
            valm_q      <= 64'h0;
            cnd_q       <= 1'b0;
            wait_cnt    <= 8'd0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (imem_error)        stat <= STAT_ADR;
                    else if (!instr_valid) stat <= STAT_INS;
                    else if (icode == 4'h0) begin
                        stat        <= STAT_HLT;
                        instr_count <= instr_count + 32'd1;
                    end else begin
                        icode_q <= icode;
                        valc_q  <= valC;
                        valp_q  <= valP;
                    end
                end
                S_EXEC: begin
                    cnd_q    <= Cnd;
                    wait_cnt <= 8'd0;
                end
                S_MEM: begin
                    wait_cnt <= wait_cnt + 8'd1;
                    if (dmem_done) begin
                        if (dmem_error) stat   <= STAT_ADR;
                        else            valm_q <= valM;
                    end else if (mem_timeout) begin
                        stat <= STAT_ADR;
                    end
                end
                S_PCUPD: begin
                    PC          <= sel_next_pc(icode_q, cnd_q, valc_q, valp_q, valm_q);
                    instr_count <= instr_count + 32'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/y86_seq_ctrl.md
Name: y86_seq_ctrl

Overview:
Multi-cycle sequencer for the Y86-64 SEQ datapath. It owns the PC register and drives the fetch stage with that PC. It steps each instruction through the FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK and PC-update phases, emitting one-cycle stage enables and handshaking with data memory. It also resolves the next PC and maintains the architectural status code, halting on HLT, invalid instruction or memory errors.

Parameters:
RESET_PC, 64'h0, PC value loaded on reset
MEM_TIMEOUT, 16, maximum MEMORY-phase cycles without dmem_done before an ADR fault (range 1..255)

Ports:
clk  input  1  clock; all state changes on the rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  leave IDLE and begin execution at the current PC
step_mode  input  1  1 = return to IDLE after each retired instruction
icode  input  4  instruction code from fetch
valC  input  64  constant word from fetch
valP  input  64  sequential next PC from fetch
instr_valid  input  1  fetch reports a legal icode
imem_error  input  1  fetch reports an instruction-memory fault
Cnd  input  1  condition result from execute
valM  input  64  data-memory read value
dmem_done  input  1  data-memory access complete
dmem_error  input  1  data-memory fault; qualified by dmem_done
PC  output  64  current PC driven to fetch
f_en  output  1  fetch-stage enable
d_en  output  1  decode-stage enable
e_en  output  1  execute-stage enable
w_en  output  1  writeback/register-file write enable
dmem_req  output  1  data-memory request
stat  output  3  status: 1 AOK, 2 HLT, 3 ADR, 4 INS
busy  output  1  high in any state except IDLE and HALT
instr_count  output  32  retired-instruction counter, wraps at 2^32

Behaviour:
- Reset, when rst_n = 0 at a rising edge, regardless of state:
  - state IDLE, PC = RESET_PC, stat = 1, instr_count = 0.
  - All enables, dmem_req and busy = 0.
  - Latched icode, valC, valP, Cnd and valM registers cleared.
  - An in-flight memory request drops on the next cycle.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, PCUPD, HALT. Enables and dmem_req are Moore outputs of the state.
- IDLE: all enables 0. start = 1 -> FETCH.
- FETCH: f_en = 1 for one cycle. Fetch inputs are sampled at the end of this cycle, in this priority:
  - imem_error -> stat = 3, go to HALT.
  - else !instr_valid -> stat = 4, go to HALT.
  - else icode = 0 -> stat = 2, instr_count + 1, PC unchanged, go to HALT.
  - else latch icode, valC, valP and go to DECODE.
- DECODE: d_en = 1 for one cycle -> EXEC.
- EXEC: e_en = 1 for one cycle; Cnd is latched.
  - Latched icode in {4,5,8,9,A,B} -> MEM.
  - Otherwise -> WB.
- MEM: dmem_req = 1 continuously, and an internal wait counter increments each cycle.
  - dmem_done = 1 with dmem_error = 1 -> stat = 3, go to HALT.
  - dmem_done = 1 with dmem_error = 0 -> latch valM, go to WB.
  - If the counter reaches MEM_TIMEOUT with no dmem_done, the fault is taken that cycle: stat = 3, go to HALT.
  - dmem_done in the first MEM cycle gives a 1-cycle MEM phase.
  - The counter clears on entry to MEM.
- WB: w_en = 1 for one cycle -> PCUPD.
- PCUPD: PC updated by latched icode:
  - 8 (call): PC = valC.
  - 7 (jXX): PC = Cnd ? valC : valP.
  - 9 (ret): PC = valM.
  - otherwise: PC = valP.
  - Same edge: instr_count + 1, then -> IDLE if step_mode, else -> FETCH.
- HALT: absorbing state. Enables, dmem_req and busy = 0; PC and stat frozen; start ignored. Only reset exits.
- Latency per instruction:
  - Non-memory instruction: 5 cycles (FETCH through PCUPD).
  - Memory instruction: 5 + N cycles, where N ≥ 1 is the MEM wait.
- Stray signals: dmem_done outside MEM is ignored. start while busy is ignored.
- Counter wrap: instr_count 32'hFFFFFFFF + 1 = 0; no flag is raised.

Test Plan:
- Reset, start, irmovq (icode 3, valP = 0x0A) then nop (icode 1, valP = 0x0B) -> f/d/e/w enables pulse in order, no dmem_req, PC 0x0 -> 0x0A -> 0x0B, instr_count = 2, 5 cycles per instruction.
- jXX (icode 7, valC = 0x100, valP = 0x9): Cnd = 1 -> PC = 0x100; repeat with Cnd = 0 -> PC = 0x9.
- call (valC = 0x200) then ret with valM = 0x13 and dmem_done delayed 3 cycles -> PC 0x200, then 0x13; dmem_req high exactly 3 cycles during the ret.
- mrmovq with dmem_done never asserted, MEM_TIMEOUT = 16 -> dmem_req high 16 cycles, then stat = 3, HALT, busy = 0; a later start is ignored.
- Separate runs:
  - imem_error = 1 at FETCH -> stat 3.
  - instr_valid = 0 -> stat 4.
  - icode = 0 -> stat 2, instr_count + 1, PC unchanged.
- rst_n low during MEM with dmem_req high -> next cycle state IDLE, dmem_req = 0, PC = RESET_PC, stat = 1, instr_count = 0. Separately, step_mode = 1 -> returns to IDLE after each PCUPD.
